// File: rtl/fog_pkg.sv
// Shared definitions for the FOG PIG loop blocks: FSM state encoding,
// averaging exponent constants and the averaging-exponent clamp.
package fog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_H  = 3'd1,
        ST_WAIT_H = 3'd2,
        ST_ACQ_H  = 3'd3,
        ST_SET_L  = 3'd4,
        ST_WAIT_L = 3'd5,
        ST_ACQ_L  = 3'd6,
        ST_OUT    = 3'd7
    } fog_state_e;

    typedef enum logic [3:0] {
        MV_EXP_0  = 4'd0,
        MV_EXP_1  = 4'd1,
        MV_EXP_2  = 4'd2,
        MV_EXP_3  = 4'd3,
        MV_EXP_4  = 4'd4,
        MV_EXP_5  = 4'd5,
        MV_EXP_6  = 4'd6,
        MV_EXP_7  = 4'd7,
        MV_EXP_8  = 4'd8,
        MV_EXP_9  = 4'd9,
        MV_EXP_10 = 4'd10,
        MV_EXP_11 = 4'd11,
        MV_EXP_12 = 4'd12
    } mv_exp_e;

    localparam int unsigned FOG_MAX_SHIFT = 32'd12;
    localparam int unsigned FOG_DEF_SHIFT = 32'd7;

    // Out-of-range exponents fall back to the default averaging depth.
    function automatic logic [3:0] clamp_shift(input logic [3:0] sel,
                                               input logic [3:0] max_shift,
                                               input logic [3:0] def_shift);
        logic [3:0] res;
        if (sel > max_shift) begin
            res = def_shift;
        end else begin
            res = sel;
        end
        return res;
    endfunction

endpackage

// File: rtl/dither_trig_gen.sv
// Free-running sample trigger: one-clock pulse every period_cnt+1 clocks,
// first pulse on the first clock after reset release.
module dither_trig_gen #(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] period_cnt,
    output logic          trig
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] pc_r;
    logic [CW-1:0] pc_s;
    logic          trig_r;
    logic          trig_s;

    // Down-counter: reload and fire on zero, otherwise count down.
    always_comb begin
        pc_s   = pc_r;
        trig_s = 1'b0;
        if (pc_r == CNT_ZERO) begin
            pc_s   = period_cnt;
            trig_s = 1'b1;
        end else begin
            pc_s   = pc_r - CNT_ONE;
            trig_s = 1'b0;
        end
    end

    // Counter and trigger registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= CNT_ZERO;
            trig_r <= 1'b0;
        end else begin
            pc_r   <= pc_s;
            trig_r <= trig_s;
        end
    end

    assign trig = trig_r;

endmodule

// File: rtl/dither_gen_v3.sv
// Square-wave dither generator with synchronous demodulator: averages the
// returned samples per half-period and reports mean and half-difference.
module dither_gen_v3
    import fog_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned CW        = 32,
    parameter int unsigned MAX_SHIFT = FOG_MAX_SHIFT,
    parameter int unsigned DEF_SHIFT = FOG_DEF_SHIFT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_dither_high,
    input  logic signed [DW-1:0] i_dither_low,
    input  logic        [CW-1:0] i_period_cnt,
    input  logic        [CW-1:0] i_wait_cnt,
    input  logic        [3:0]    i_avg_sel,
    input  logic signed [DW-1:0] i_data,
    output logic signed [DW-1:0] o_dither_out,
    output logic signed [DW-1:0] o_data,
    output logic signed [DW-1:0] o_diff,
    output logic                 o_valid,
    output logic                 o_trig,
    output logic        [2:0]    o_state
);

    localparam int unsigned     AW        = DW + MAX_SHIFT;
    localparam logic [3:0]      MAX_SH_L  = 4'(MAX_SHIFT);
    localparam logic [3:0]      DEF_SH_L  = 4'(DEF_SHIFT);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]   DAT_ZERO  = {DW{1'b0}};
    localparam logic [AW-1:0]   ACC_ZERO  = {AW{1'b0}};

    fog_state_e            state_r, state_s;
    logic        [CW-1:0]  tc_r, tc_s;
    logic        [CW-1:0]  wait_r, wait_s;
    logic        [3:0]     shift_r, shift_s;
    logic signed [AW-1:0]  acc_r, acc_s;
    logic signed [DW-1:0]  low_r, low_s;
    logic signed [DW-1:0]  dh_r, dh_s;
    logic signed [DW-1:0]  dl_r, dl_s;
    logic signed [DW-1:0]  d_q_r;
    logic signed [DW-1:0]  dither_r, dither_s;
    logic signed [DW-1:0]  data_r, data_s;
    logic signed [DW-1:0]  diff_r, diff_s;
    logic                  valid_r, valid_s;
    logic                  trig_s;

    logic signed [AW-1:0]  d_ext_s;
    logic signed [DW-1:0]  avg_s;
    logic signed [DW:0]    sum_s;
    logic signed [DW:0]    dif_s;
    logic        [CW-1:0]  acq_load_s;

    dither_trig_gen #(
        .CW (CW)
    ) u_trig (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .period_cnt (i_period_cnt),
        .trig       (trig_s)
    );

    // Widened arithmetic: sum/difference at DW+1 bits cannot overflow.
    always_comb begin
        d_ext_s    = {{MAX_SHIFT{d_q_r[DW-1]}}, d_q_r};
        avg_s      = DW'(acc_r >>> shift_r);
        sum_s      = $signed({dh_r[DW-1], dh_r}) + $signed({dl_r[DW-1], dl_r});
        dif_s      = $signed({dh_r[DW-1], dh_r}) - $signed({dl_r[DW-1], dl_r});
        acq_load_s = CNT_ONE << shift_r;
    end

    // Next-state and datapath update; a trigger on an exit cycle is dropped.
    always_comb begin
        state_s  = state_r;
        tc_s     = tc_r;
        wait_s   = wait_r;
        shift_s  = shift_r;
        acc_s    = acc_r;
        low_s    = low_r;
        dh_s     = dh_r;
        dl_s     = dl_r;
        dither_s = dither_r;
        data_s   = data_r;
        diff_s   = diff_r;
        valid_s  = 1'b0;
        if (!i_en) begin
            state_s  = ST_IDLE;
            dither_s = DAT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trig_s) begin
                        state_s = ST_SET_H;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SET_H: begin
                    dither_s = i_dither_high;
                    low_s    = i_dither_low;
                    wait_s   = i_wait_cnt;
                    shift_s  = clamp_shift(i_avg_sel, MAX_SH_L, DEF_SH_L);
                    acc_s    = ACC_ZERO;
                    tc_s     = CNT_ZERO;
                    state_s  = ST_WAIT_H;
                end
                ST_WAIT_H, ST_WAIT_L: begin
                    if (tc_r == wait_r) begin
                        tc_s    = acq_load_s;
                        state_s = (state_r == ST_WAIT_H) ? ST_ACQ_H : ST_ACQ_L;
                    end else if (trig_s) begin
                        tc_s = tc_r + CNT_ONE;
                    end else begin
                        tc_s = tc_r;
                    end
                end
                ST_ACQ_H, ST_ACQ_L: begin
                    if (tc_r == CNT_ZERO) begin
                        if (state_r == ST_ACQ_H) begin
                            dh_s    = avg_s;
                            state_s = ST_SET_L;
                        end else begin
                            dl_s    = avg_s;
                            state_s = ST_OUT;
                        end
                    end else if (trig_s) begin
                        acc_s = acc_r + d_ext_s;
                        tc_s  = tc_r - CNT_ONE;
                    end else begin
                        acc_s = acc_r;
                    end
                end
                ST_SET_L: begin
                    dither_s = low_r;
                    acc_s    = ACC_ZERO;
                    tc_s     = CNT_ZERO;
                    state_s  = ST_WAIT_L;
                end
                ST_OUT: begin
                    data_s  = DW'(sum_s >>> 1'b1);
                    diff_s  = DW'(dif_s >>> 1'b1);
                    valid_s = 1'b1;
                    state_s = ST_SET_H;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            tc_r     <= CNT_ZERO;
            wait_r   <= CNT_ZERO;
            shift_r  <= 4'd0;
            acc_r    <= ACC_ZERO;
            low_r    <= DAT_ZERO;
            dh_r     <= DAT_ZERO;
            dl_r     <= DAT_ZERO;
            d_q_r    <= DAT_ZERO;
            dither_r <= DAT_ZERO;
            data_r   <= DAT_ZERO;
            diff_r   <= DAT_ZERO;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            tc_r     <= tc_s;
            wait_r   <= wait_s;
            shift_r  <= shift_s;
            acc_r    <= acc_s;
            low_r    <= low_s;
            dh_r     <= dh_s;
            dl_r     <= dl_s;
            d_q_r    <= i_data;
            dither_r <= dither_s;
            data_r   <= data_s;
            diff_r   <= diff_s;
            valid_r  <= valid_s;
        end
    end

    assign o_dither_out = dither_r;
    assign o_data       = data_r;
    assign o_diff       = diff_r;
    assign o_valid      = valid_r;
    assign o_trig       = trig_s;
    assign o_state      = state_r;

endmodule

// File: tb/tb_dither_gen_v3.sv
// Directed bench for dither_gen_v3 with hand-computed expected values.
module tb_dither_gen_v3;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_en;
    logic signed [31:0] i_dither_high;
    logic signed [31:0] i_dither_low;
    logic        [31:0] i_period_cnt;
    logic        [31:0] i_wait_cnt;
    logic        [3:0]  i_avg_sel;
    logic signed [31:0] i_data;
    logic signed [31:0] o_dither_out;
    logic signed [31:0] o_data;
    logic signed [31:0] o_diff;
    logic               o_valid;
    logic               o_trig;
    logic        [2:0]  o_state;

    int                 vec_cnt = 0;
    int                 err_cnt = 0;
    logic               data_mode = 1'b0;
    logic signed [31:0] data_const = 32'sd0;

    dither_gen_v3 #(
        .DW        (32),
        .CW        (32),
        .MAX_SHIFT (12),
        .DEF_SHIFT (7)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_dither_high (i_dither_high),
        .i_dither_low  (i_dither_low),
        .i_period_cnt  (i_period_cnt),
        .i_wait_cnt    (i_wait_cnt),
        .i_avg_sel     (i_avg_sel),
        .i_data        (i_data),
        .o_dither_out  (o_dither_out),
        .o_data        (o_data),
        .o_diff        (o_diff),
        .o_valid       (o_valid),
        .o_trig        (o_trig),
        .o_state       (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Sample source: constant, or +50/-30 following the current dither level.
    initial begin
        i_data = 32'sd0;
        forever begin
            @(negedge i_clk);
            if (data_mode) begin
                i_data = (o_dither_out == i_dither_high) ? 32'sd50 : -32'sd30;
            end else begin
                i_data = data_const;
            end
        end
    end

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (o_state != st && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check_val(tag, o_state, st);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (o_valid !== 1'b1 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check_val(tag, o_valid, 1);
    endtask

    task automatic count_state(input logic [2:0] st, input int budget, output int n);
        n = 0;
        while (o_state == st && n < budget) begin
            n++;
            @(negedge i_clk);
        end
    endtask

    task automatic restart(input logic [31:0] per, input logic [31:0] wt,
                           input logic [3:0] sel, input logic signed [31:0] dval);
        i_en = 1'b0;
        step(2);
        check_val("idle_state", o_state, 0);
        i_period_cnt = per;
        i_wait_cnt   = wt;
        i_avg_sel    = sel;
        data_const   = dval;
        i_en         = 1'b1;
    endtask

    initial begin
        int n;
        i_rst_n       = 1'b0;
        i_en          = 1'b0;
        i_dither_high = 32'sd20;
        i_dither_low  = -32'sd20;
        i_period_cnt  = 32'd3;
        i_wait_cnt    = 32'd0;
        i_avg_sel     = 4'd0;
        data_const    = 32'sd100;
        step(3);
        check_val("rst_dither", o_dither_out, 0);
        check_val("rst_data", o_data, 0);
        check_val("rst_diff", o_diff, 0);
        check_val("rst_valid", o_valid, 0);
        check_val("rst_trig", o_trig, 0);
        check_val("rst_state", o_state, 0);

        // Trigger: first pulse right after release, then every 4 clocks.
        i_rst_n = 1'b1;
        step(1);
        check_val("first_trig", o_trig, 1);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                step(1);
                n++;
            end while (!o_trig && n < 20);
            check_val("trig_spacing", n, 4);
        end

        // Constant input, single sample per half.
        i_en = 1'b1;
        wait_state("t1_acq_h", 3'd3, 100);
        check_val("t1_dither_h", o_dither_out, 20);
        wait_state("t1_acq_l", 3'd6, 100);
        check_val("t1_dither_l", o_dither_out, -20);
        wait_valid("t1_valid", 200);
        check_val("t1_data", o_data, 100);
        check_val("t1_diff", o_diff, 0);
        step(1);
        check_val("t1_valid_width", o_valid, 0);
        wait_valid("t1_valid2", 200);
        check_val("t1_data2", o_data, 100);

        // Level-dependent input: mean 10, half-difference 40.
        restart(32'd0, 32'd0, 4'd2, 32'sd0);
        data_mode = 1'b1;
        wait_valid("t2_valid", 300);
        check_val("t2_data", o_data, 10);
        check_val("t2_diff", o_diff, 40);
        data_mode = 1'b0;

        // Out-of-range exponent clamps to 128 samples; negative average.
        restart(32'd0, 32'd0, 4'd15, -32'sd7);
        wait_state("t3_acq_h", 3'd3, 100);
        count_state(3'd3, 1000, n);
        check_val("t3_acq_len", n, 129);
        wait_valid("t3_valid", 1000);
        check_val("t3_data", o_data, -7);
        check_val("t3_diff", o_diff, 0);

        // Full-scale input at the deepest average.
        restart(32'd0, 32'd0, 4'd12, 32'sh7FFF_FFFF);
        wait_valid("t4_valid", 10000);
        check_val("t4_data", o_data, 32'sh7FFF_FFFF);
        check_val("t4_diff", o_diff, 0);

        // Mid-acquisition level change only lands at the next SET_H.
        restart(32'd0, 32'd2, 4'd4, 32'sd60);
        wait_state("t5_acq_h", 3'd3, 100);
        i_dither_high = 32'sd99;
        step(3);
        check_val("t5_dither_hold", o_dither_out, 20);
        wait_state("t5_acq_l", 3'd6, 200);
        check_val("t5_dither_l", o_dither_out, -20);
        wait_valid("t5_valid", 200);
        check_val("t5_data", o_data, 60);
        wait_state("t5_wait_h", 3'd2, 20);
        check_val("t5_dither_new", o_dither_out, 99);
        count_state(3'd2, 100, n);
        check_val("t5_wait_len", n, 3);

        // Enable drop during the low acquisition.
        wait_state("t6_acq_l", 3'd6, 200);
        i_en = 1'b0;
        step(1);
        check_val("t6_state", o_state, 0);
        check_val("t6_dither", o_dither_out, 0);
        check_val("t6_valid", o_valid, 0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (o_valid) n++;
        end
        check_val("t6_no_valid", n, 0);
        check_val("t6_data_hold", o_data, 60);

        // Asynchronous reset in the middle of a cycle.
        i_en = 1'b1;
        wait_state("t7_acq_h", 3'd3, 100);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_val("t7_dither", o_dither_out, 0);
        check_val("t7_data", o_data, 0);
        check_val("t7_diff", o_diff, 0);
        check_val("t7_valid", o_valid, 0);
        check_val("t7_trig", o_trig, 0);
        check_val("t7_state", o_state, 0);
        step(1);
        i_rst_n = 1'b1;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dither_gen_v3.md
# dither_gen_v3

Parametrised square-wave dither generator and synchronous demodulator for the FOG PIG loop. It drives a two-level dither onto the modulation path, waits a programmable number of sample triggers, then averages the returned samples in each half-period. Per dither cycle it outputs the common-mode mean and the half-difference (the dither-error term) with a valid strobe. It sits between the ADC sample path and the modulation DAC summing node, and generates its own sample trigger.

## Interface
- DW, 32: data, dither and result width (signed).
- CW, 32: width of period and wait counters.
- MAX_SHIFT, 12: largest averaging exponent; accumulator width is DW+MAX_SHIFT.
- DEF_SHIFT, 7: exponent used when i_avg_sel > MAX_SHIFT.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  run enable; low forces IDLE.
- i_dither_high  in  DW  signed high dither level.
- i_dither_low  in  DW  signed low dither level.
- i_period_cnt  in  CW  trigger period minus one, in clocks.
- i_wait_cnt  in  CW  settle triggers after each level change.
- i_avg_sel  in  4  averaging exponent; 2^i_avg_sel samples per half.
- i_data  in  DW  signed demodulator input sample.
- o_dither_out  out  DW  signed dither drive.
- o_data  out  DW  signed mean (H+L)>>>1.
- o_diff  out  DW  signed half-difference (H−L)>>>1.
- o_valid  out  1  one-clock pulse when o_data/o_diff update.
- o_trig  out  1  internal sample trigger, for the ADC and debug.
- o_state  out  3  current FSM state encoding.

## Operation
- Trigger: down-counter pc. When pc==0, set trig=1 and reload pc with i_period_cnt; otherwise set trig=0 and decrement pc. Period is i_period_cnt+1 clocks; i_period_cnt=0 gives a trigger every clock. The trigger runs regardless of i_en.
- Input pipeline: i_data is registered once (d_q). Each accumulation adds d_q on a trig cycle.
- Config snapshot: in SET_H, latch dither_high, dither_low, wait_cnt and shift (clamped to DEF_SHIFT if >MAX_SHIFT). Input changes mid-cycle take effect at the next SET_H.
- States, encoding 0..7:
  - IDLE (0): leave when i_en=1 and trig=1 → SET_H.
  - SET_H (1): o_dither_out←high; clear acc and tc → WAIT_H.
  - WAIT_H (2): count triggers in tc; when tc==wait_cnt → ACQ_H and load tc←2^shift. With wait_cnt=0, the state exits on the next clock.
  - ACQ_H (3): on trig, acc+=d_q and tc−=1; when tc==0, dH←acc>>>shift → SET_L.
  - SET_L (4): o_dither_out←low; clear acc and tc → WAIT_L.
  - WAIT_L (5) and ACQ_L (6): mirror of the high half; on completion dL←acc>>>shift → OUT.
  - OUT (7): compute o_data and o_diff, pulse o_valid → SET_H.
- Arithmetic:
  - acc is signed DW+MAX_SHIFT bits, so it never overflows.
  - The averaged result is truncated to DW bits.
  - The sum and difference are formed at DW+1 bits, arithmetic shifted right by 1, then truncated to DW. This cannot overflow.
- i_en low in any state: next state IDLE and o_dither_out←0 on the next clock. o_data and o_diff keep their last values; o_valid=0.

## Timing
- Reset values: o_dither_out=0, o_data=0, o_diff=0, o_valid=0, o_trig=0, o_state=IDLE, pc=0, acc=0. The first trigger occurs on the first clock after reset release.
- All outputs are registered. o_dither_out changes one clock after entering SET_H or SET_L.
- o_valid goes high the clock after the FSM is in OUT and stays high for exactly one clock. o_data and o_diff change on that same edge.
- A trig landing in the same clock as a state transition is consumed only by the state being exited. SET_x and OUT never count a trigger.
- Cycle length in triggers ≈ 2·(wait_cnt+1+2^shift); exact clock counts are covered by the test plan.
- Mid-operation reset: all registers return to their reset values immediately.

## Structure
- Shared package fog_pkg holds:
  - the state enum, 3 bits;
  - the MV exponent constants 0..12 and DEF_SHIFT;
  - the clamp function for shift.
- Sub-module dither_trig_gen (parameter CW) implements the period counter and trigger. The module is reused by other loop blocks.

## Test plan
- Period 3, wait 0, avg_sel 0, H=20, L=−20, i_data=const 100 → o_trig every 4 clocks; o_data=100, o_diff=0; o_valid pulses once per cycle.
- i_data=+50 while dither high and −30 while low, avg_sel 2 (4 samples) → o_data=10, o_diff=40.
- avg_sel=15 → 128 samples per half, matching DEF_SHIFT; a negative constant −7 averages to −7 (arithmetic shift).
- i_data=0x7FFFFFFF in both halves, avg_sel 12 → no overflow; o_data=0x7FFFFFFF.
- Change i_dither_high mid ACQ_H → o_dither_out unchanged until the next SET_H.
- Drop i_en during ACQ_L → IDLE next clock; o_dither_out=0; no o_valid. Pulse i_rst_n low mid-cycle → all outputs at reset values asynchronously.
